// File: rtl/sensor_sched_pkg.sv
// Shared types and defaults for the sensor query scheduler.
// FSM state encoding plus default timing constants.
package sensor_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } state_t;

  localparam int DEF_N_CH     = 4;
  localparam int CH_W         = $clog2(DEF_N_CH);
  localparam int DEF_PRESCALE = 50000;
  localparam int DEF_TIMEOUT  = 100;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing a one-cycle tick.
// tick is high while the count sits at PRESCALE-1.
module tick_prescaler
  import sensor_sched_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == PW'(PRESCALE - 1));
  assign tick   = w_last;

  // count 0..PRESCALE-1 and wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/sensor_query_scheduler.sv
// Periodic per-channel query scheduler with a round-robin
// arbiter sharing one sensor transaction engine.
module sensor_query_scheduler
  import sensor_sched_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 16,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [$clog2(N_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]        cfg_period,
  output logic                    req_valid,
  output logic [$clog2(N_CH)-1:0] req_ch,
  input  logic                    req_ready,
  input  logic                    done,
  output logic                    busy,
  output logic                    timeout,
  output logic [N_CH-1:0]         overrun
);

  localparam int CW = $clog2(N_CH);

  logic             w_tick;
  logic [CNT_W-1:0] r_period [N_CH];
  logic [CNT_W-1:0] r_cnt    [N_CH];
  logic [N_CH-1:0]  r_pending;
  logic [N_CH-1:0]  r_overrun;
  state_t           r_state;
  logic [CW-1:0]    r_rr;
  logic [CW-1:0]    r_req_ch;
  logic             r_req_valid;
  logic             r_busy;
  logic             r_timeout;
  logic [CNT_W-1:0] r_to_cnt;
  logic             w_accept;
  logic [N_CH-1:0]  w_clr;
  logic [CW-1:0]    w_pick;
  logic [CW-1:0]    w_rr_next;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .tick(w_tick)
  );

  // first pending channel at or after ptr, wrapping
  function automatic logic [CW-1:0] f_pick(
    input logic [N_CH-1:0] pend,
    input logic [CW-1:0]   ptr
  );
    logic [CW-1:0] sel;
    logic          found;
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && pend[i] && (CW'(i) >= ptr)) begin
        sel   = CW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (!found && pend[i]) begin
        sel   = CW'(i);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign w_pick    = f_pick(r_pending, r_rr);
  assign w_accept  = (r_state == ISSUE) && r_req_valid && req_ready;
  assign w_rr_next = (r_req_ch == CW'(N_CH - 1)) ? '0
                   : r_req_ch + CW'(1);

  // one-hot clear of the channel whose request is accepted
  always_comb begin
    w_clr = '0;
    if (w_accept) begin
      w_clr[r_req_ch] = 1'b1;
    end
  end

  // per-channel period counters, pending and overrun flags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        r_period[i] <= '0;
        r_cnt[i]    <= '0;
      end
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cfg_we && (cfg_ch == CW'(i))) begin
          r_period[i]  <= cfg_period;
          r_cnt[i]     <= cfg_period;
          r_pending[i] <= 1'b0;
          r_overrun[i] <= 1'b0;
        end else begin
          if (w_clr[i]) begin
            r_pending[i] <= 1'b0;
          end
          if (w_tick && (r_period[i] != '0)) begin
            if (r_cnt[i] == CNT_W'(1)) begin
              r_cnt[i] <= r_period[i];
              if (r_pending[i] && !w_clr[i]) begin
                r_overrun[i] <= 1'b1;
              end else begin
                r_pending[i] <= 1'b1;
              end
            end else begin
              r_cnt[i] <= r_cnt[i] - CNT_W'(1);
            end
          end
        end
      end
    end
  end

  // arbiter FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr        <= '0;
      r_req_ch    <= '0;
      r_req_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      r_timeout   <= 1'b0;
      r_busy      <= (r_state != IDLE);
      r_req_valid <= (r_state == ISSUE) && !w_accept;
      unique case (r_state)
        IDLE: begin
          if (|r_pending) begin
            r_req_ch <= w_pick;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (w_accept) begin
            r_rr     <= w_rr_next;
            r_to_cnt <= '0;
            r_state  <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (done) begin
            r_state <= IDLE;
          end else if (w_tick) begin
            if (r_to_cnt == CNT_W'(TIMEOUT - 1)) begin
              r_timeout <= 1'b1;
              r_state   <= IDLE;
            end else begin
              r_to_cnt <= r_to_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_valid = r_req_valid;
  assign req_ch    = r_req_ch;
  assign busy      = r_busy;
  assign timeout   = r_timeout;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_sensor_query_scheduler.sv
// Directed bench for sensor_query_scheduler.
// PRESCALE=4, TIMEOUT=3, N_CH=4; ticks land on cycles 3,7,11,...
module tb_sensor_query_scheduler;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_period;
  logic        req_valid;
  logic [1:0]  req_ch;
  logic        req_ready;
  logic        done;
  logic        busy;
  logic        timeout;
  logic [3:0]  overrun;

  int tests;
  int fails;

  sensor_query_scheduler #(
    .N_CH    (4),
    .CNT_W   (16),
    .PRESCALE(4),
    .TIMEOUT (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_period(cfg_period),
    .req_valid (req_valid),
    .req_ch    (req_ch),
    .req_ready (req_ready),
    .done      (done),
    .busy      (busy),
    .timeout   (timeout),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // two reset edges; returns in cycle 0 with prescaler at 0
  task automatic do_reset();
    rst        = 1'b1;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_period = '0;
    req_ready  = 1'b0;
    done       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (req_valid !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0 ||
        overrun !== 4'b0 || req_ch !== 2'd0) begin
      fails++;
      $display("FAIL reset_values v=%b b=%b t=%b o=%b ch=%0d want 0",
               req_valid, busy, timeout, overrun, req_ch);
    end
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_period = 16'd1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      cfg_we = 1'b0;
    end
    tests++;
    if (req_valid !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_pre_issue v=%b b=%b want 1 1", req_valid, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (req_valid !== 1'b0 || busy !== 1'b0 || overrun !== 4'b0) begin
      fails++;
      $display("FAIL reset_mid v=%b b=%b o=%b want 0 0 0",
               req_valid, busy, overrun);
    end
    req_ready = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      tests++;
      if (req_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_quiet c=%0d req_valid=%b want 0", c, req_valid);
      end
    end
  endtask

  task automatic test_single();
    logic ev;
    do_reset();
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_period = 16'd3;
    req_ready = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      ev = (c == 14 || c == 26 || c == 38);
      tests++;
      if (req_valid !== ev || (ev && req_ch !== 2'd1)) begin
        fails++;
        $display("FAIL single c=%0d req_valid=%b ch=%0d want %b ch=1",
                 c, req_valid, req_ch, ev);
      end
      cfg_we = 1'b0;
      done = (c == 16 || c == 28 || c == 40);
    end
    done = 1'b0;
  endtask

  task automatic test_round_robin();
    logic       ev;
    logic       prev;
    logic [1:0] ech;
    do_reset();
    req_ready = 1'b1;
    prev = 1'b0;
    for (int c = 1; c <= 31; c++) begin
      @(negedge clk);
      ev  = (c == 14 || c == 18 || c == 22 || c == 26 || c == 30);
      ech = 2'(((c - 14) / 4) % 4);
      tests++;
      if (req_valid !== ev || (ev && req_ch !== ech)) begin
        fails++;
        $display("FAIL round_robin c=%0d req_valid=%b ch=%0d want %b ch=%0d",
                 c, req_valid, req_ch, ev, ech);
      end
      cfg_we     = (c >= 3 && c <= 6);
      cfg_ch     = 2'(c - 3);
      cfg_period = 16'd2;
      done = prev;
      prev = req_valid;
    end
    cfg_we = 1'b0;
    done   = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset();
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_period = 16'd1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c >= 6 && c <= 12) begin
        tests++;
        if (req_valid !== 1'b1 || req_ch !== 2'd2) begin
          fails++;
          $display("FAIL overrun_hold c=%0d v=%b ch=%0d want 1 ch=2",
                   c, req_valid, req_ch);
        end
      end
      if (c == 13) begin
        tests++;
        if (req_valid !== 1'b0) begin
          fails++;
          $display("FAIL overrun_accept req_valid=%b want 0", req_valid);
        end
      end
      if (c == 7 || c == 10 || c == 12) begin
        tests++;
        if (overrun !== 4'b0000) begin
          fails++;
          $display("FAIL overrun_clear c=%0d overrun=%b want 0000", c, overrun);
        end
      end
      if (c == 8) begin
        tests++;
        if (overrun !== 4'b0100) begin
          fails++;
          $display("FAIL overrun_set overrun=%b want 0100", overrun);
        end
      end
      cfg_we    = (c == 9);
      req_ready = (c == 12);
    end
    req_ready = 1'b0;
  endtask

  task automatic test_timeout(input logic with_done);
    logic et;
    do_reset();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = 16'd1;
    req_ready = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 6) begin
        tests++;
        if (req_valid !== 1'b1) begin
          fails++;
          $display("FAIL timeout_req req_valid=%b want 1", req_valid);
        end
      end
      if (c >= 7) begin
        et = !with_done && (c == 16);
        tests++;
        if (timeout !== et) begin
          fails++;
          $display("FAIL timeout_pulse d=%b c=%0d timeout=%b want %b",
                   with_done, c, timeout, et);
        end
      end
      if (c == 16 || c == 17) begin
        tests++;
        if (busy !== (c == 16)) begin
          fails++;
          $display("FAIL timeout_busy d=%b c=%0d busy=%b want %b",
                   with_done, c, busy, (c == 16));
        end
      end
      cfg_we     = (c == 8);
      cfg_period = 16'd0;
      done       = with_done && (c == 15);
    end
    done = 1'b0;
  endtask

  task automatic test_disable();
    do_reset();
    req_ready = 1'b1;
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = 16'd2;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      tests++;
      if (req_valid !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL disable c=%0d v=%b busy=%b want 0 0",
                 c, req_valid, busy);
      end
      cfg_we     = (c == 1);
      cfg_period = 16'd0;
      done       = 1'b1;
    end
    cfg_we = 1'b0;
    done   = 1'b0;
  endtask

  task automatic test_collision();
    logic ev;
    do_reset();
    req_ready = 1'b1;
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_period = 16'd2;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      ev = (c == 18);
      tests++;
      if (req_valid !== ev || (ev && req_ch !== 2'd1)) begin
        fails++;
        $display("FAIL collision c=%0d v=%b ch=%0d want %b ch=1",
                 c, req_valid, req_ch, ev);
      end
      cfg_we = (c == 7);
    end
    cfg_we = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_overrun();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_disable();
    test_collision();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sensor_query_scheduler.md
# sensor_query_scheduler

Periodic query scheduler that decides when each sensor channel is polled and shares the single sensor-bus transaction engine among them. A prescaler derives a slow tick from `clk`. Per-channel down-counters expire at programmed periods, and a round-robin arbiter issues one query at a time over a valid/ready request plus `done` handshake. It sits between the host/UART command decoder (configuration) and the sensor interface FSM (execution), and replaces free-running counters for timing sensor reads.

## Interface
- `N_CH`, 4: number of sensor channels (2..8)
- `CNT_W`, 16: width of period and timeout counters
- `PRESCALE`, 50000: `clk` cycles per tick (≥2)
- `TIMEOUT`, 100: ticks allowed in WAIT_DONE before abort (≥1)

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `cfg_we`  in  1  write one channel's configuration this cycle
- `cfg_ch`  in  $clog2(N_CH)  channel being written
- `cfg_period`  in  CNT_W  period in ticks; 0 disables the channel
- `req_valid`  out  1  query request to the sensor engine
- `req_ch`  out  $clog2(N_CH)  channel being queried; stable while `req_valid`
- `req_ready`  in  1  sensor engine accepts the request
- `done`  in  1  one-cycle pulse: current query finished
- `busy`  out  1  FSM not in IDLE
- `timeout`  out  1  one-cycle pulse: WAIT_DONE aborted
- `overrun`  out  N_CH  sticky per channel: expired while still pending

## Operation
- Prescaler counts 0..PRESCALE-1 and wraps. `tick` is high in the cycle the count equals PRESCALE-1.
- Per channel: `period[i]`, down-counter `cnt[i]`, `pending[i]`.
- `cfg_we` loads `period[cfg_ch]` and `cnt[cfg_ch]` with `cfg_period`, and clears `pending` and `overrun` for that channel.
- On `tick`, every channel with period≠0 decrements. When `cnt==1`, it reloads `period` and sets `pending`. If `pending` is already set, it sets `overrun` instead; `pending` stays 1.
- FSM states:
  - IDLE: if any pending, select the first pending channel at or after `rr_ptr` (wrapping), register `req_ch`, go to ISSUE.
  - ISSUE: `req_valid`=1. On `req_ready`, clear `pending[req_ch]`, set `rr_ptr`=`req_ch`+1 mod N_CH, go to WAIT_DONE.
  - WAIT_DONE: count ticks. On `done`, go to IDLE. If the tick count reaches TIMEOUT before `done`, pulse `timeout` and go to IDLE.
- `done` outside WAIT_DONE is ignored.
- Simultaneous events:
  - `cfg_we` and expiry on the same channel: `cfg_we` wins; nothing is set.
  - `cfg_we` on the channel currently in ISSUE: the request completes normally; `pending` stays cleared.
  - `done` and timeout in the same cycle: `done` wins; no `timeout` pulse.
- Reset mid-operation: immediate return to the reset state. Any outstanding sensor transaction is abandoned.

## Timing
- Reset values:
  - prescaler 0, all `period`/`cnt`/`pending`/`overrun` 0, `rr_ptr` 0, state IDLE
  - `req_valid` 0, `req_ch` 0, `busy` 0, `timeout` 0
- First expiry occurs `cfg_period` ticks after the write; subsequent expiries follow every `cfg_period` ticks.
- `pending` is set in the cycle after the expiring tick.
- Latency from `pending` set to `req_valid` (FSM idle): 2 cycles. IDLE→ISSUE takes one edge; `req_valid` is a registered state decode.
- `req_valid` remains high until `req_ready`. Zero-wait accept gives exactly 1 cycle of `req_valid`.
- `busy` = state≠IDLE, registered.
- The WAIT_DONE timeout counter resets on entry.
- All counters wrap modulo 2^CNT_W. Period 1 expires on every tick.

## Structure
- Package `sensor_sched_pkg`: state enum (IDLE, ISSUE, WAIT_DONE), `CH_W`=$clog2(N_CH), default PRESCALE/TIMEOUT constants.
- Sub-module `tick_prescaler`: parameter PRESCALE; ports `clk`, `rst`, output `tick`. It is reused by other timing blocks.
- Round-robin pick is a combinational function in the main module.

## Test plan
(PRESCALE=4, TIMEOUT=3, N_CH=4 unless noted)
- Reset: assert `rst` for 2 cycles during ISSUE → `req_valid`=0, `busy`=0, `overrun`=0, no request for 10 ticks.
- Single channel: write ch1 period 3, `req_ready` tied 1, `done` 2 cycles after accept → `req_valid` with `req_ch`=1 every 12 cycles; first at write+12+2 cycles.
- Round-robin: ch0..ch3 all period 2, written in the same-tick window → grants issue in order 0,1,2,3. Then 0 is next after 3.
- Overrun: ch2 period 1, hold `req_ready`=0 for 3 ticks → `overrun[2]`=1 after the second expiry. Writing ch2 clears it; `req_valid` stays asserted with `req_ch`=2 throughout.
- Timeout: accept a request, never pulse `done` → `timeout` pulses exactly once, 3 ticks after entering WAIT_DONE, and `busy` falls the next cycle. `done` coincident with the third tick → no `timeout`.
- Disable/collision: write ch0 period 0 → no ch0 requests. Write ch1 in the same cycle as its expiry → no `pending`, and the next expiry occurs `cfg_period` ticks later.
